fpu_sched: RTL and testbench
============================

# fpu_sched

Round-robin scheduler that shares one single-precision `fpu` instance between `NREQ` requesters. Each requester has a valid/ready request channel. Accepted operations are issued one per cycle into the FPU's one-cycle registered datapath. Results return in issue order on a shared, backpressurable response channel that carries the requester id. The block sits between client engines and the FPU; the FPU is instantiated alongside it, not inside it.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `FIFO_DEPTH`, 4: response buffer entries, ≥3, power of two.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  per-requester accept; at most one bit high.
- `req_a`  in  NREQ*32  operand A per requester; requester i uses [32i+31:32i].
- `req_b`  in  NREQ*32  operand B per requester.
- `req_op`  in  NREQ*2  opcode per requester: 00 add, 01 sub, 10 div, 11 mul.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response consumer accept.
- `rsp_id`  out  $clog2(NREQ)  originating requester.
- `rsp_data`  out  32  IEEE-754 result.
- `rsp_err`  out  1  unsupported-operation flag.
- `fpu_a`, `fpu_b`  out  32  registered operands to the FPU.
- `fpu_op`  out  2  registered opcode to the FPU.
- `fpu_outp`  in  32  FPU result, valid one edge after it samples its inputs.
- `busy`  out  1  high while any operation is in flight or buffered.

## Operation
- Arbitration is round-robin.
  - Pointer `last` holds the index of the last granted requester.
  - Priority order is `last+1` onward, with wrap-around.
  - `last` updates only on an accepted transfer.
- `req_ready[i]` is combinational and depends on `req_valid`. It is high only for the winning valid requester, and only when the credit check passes.
- Credit check: `occ = s1 + s2 + fifo_count`, where `s1` and `s2` are the stage-valid bits. Issue is allowed only when `occ < FIFO_DEPTH`.
  - A pop in the same cycle is not credited; the check is deliberately conservative.
- Issue on accept:
  - Operands and opcode are registered into `fpu_a`, `fpu_b`, `fpu_op`.
  - Stage 1 is set with tag `{id, err}`.
  - The next edge advances stage 1 into stage 2, which is the cycle in which the FPU samples the operands.
  - On the edge after that, `fpu_outp` and the stage-2 tag are pushed into the FIFO.
- When no request is accepted, `fpu_a`, `fpu_b` and `fpu_op` hold their values. Stage bits clear.
- FIFO:
  - `rsp_*` are driven from the head entry.
  - Pop on `rsp_valid & rsp_ready`.
  - Push and pop in the same cycle are both performed.
  - A push into a full FIFO cannot occur because of the credit check; a simulation assertion flags it.
- `busy = s1 | s2 | (fifo_count != 0)`.
- Reset, at any time including mid-operation:
  - In-flight operations and FIFO contents are discarded.
  - No response is emitted for discarded work.
  - `last` is set to `NREQ-1`, so requester 0 has first priority.

## Timing
- Reset values:
  - `req_ready` = 0 (combinational, but blocked because there are no valid requests).
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_data` = 0, `rsp_err` = 0.
  - `fpu_a` = 0, `fpu_b` = 0, `fpu_op` = 0.
  - `busy` = 0.
- Latency: accept at edge E0, FPU samples at E1, FIFO push at E2. `rsp_valid` is high in the cycle after E2, i.e. 2 edges from accept to response.
- Throughput: one operation per cycle while `rsp_ready` is held high and `FIFO_DEPTH` ≥ 3.
- Responses are strictly in acceptance order across all requesters.
- A requester must hold valid and payload until it sees ready. Dropping valid without a handshake is permitted and causes no side effect.

## Configuration
- `FPU_SCHED_DIV_TRAP_EN` defined:
  - An opcode 10 (div) request is accepted and occupies an issue slot and credit as normal.
  - `fpu_a`, `fpu_b` and `fpu_op` are not updated for it.
  - Its response carries `rsp_data = 32'h7FC00000` and `rsp_err = 1`, substituted at FIFO push. Ordering is preserved.
- `FPU_SCHED_DIV_TRAP_EN` undefined:
  - Div is forwarded to the FPU like any other operation.
  - `rsp_data` is whatever `fpu_outp` returns.
  - `rsp_err` is tied to 0.

## Structure
- Package `fpu_sched_pkg`:
  - Opcode constants `OP_ADD`, `OP_SUB`, `OP_DIV`, `OP_MUL`.
  - `QNAN = 32'h7FC00000`.
  - Tag typedef `{id, err}`.
- Sub-module `fpu_sched_fifo`: synchronous FIFO parameterized by width and depth, with `count` output and asynchronous active-low reset.
- Arbiter, credit logic and the stage-1/stage-2 tag pipeline live in the top module.

## Test plan
- Single add: requester 0 sends A=0x3F800000, B=0x3F800000, op=00. Required: `req_ready[0]` in the same cycle; `rsp_valid` 2 edges later with `rsp_data`=0x40000000, `rsp_id`=0, `busy` low the cycle after the pop.
- Round-robin: all 4 requesters hold valid with `rsp_ready`=1. Required: grants 0,1,2,3,0… one per cycle; `rsp_id` sequence matches; a mul of 0x40000000×0x40000000 returns 0x40800000.
- Backpressure: `rsp_ready`=0 with 6 requests pending. Required: exactly `FIFO_DEPTH`=4 accepted, then `req_ready` all 0. On releasing `rsp_ready`, the 4 responses drain in order and issue resumes.
- Div trap (macro on): op=10. Required: response 0x7FC00000 with `rsp_err`=1, and `fpu_op` unchanged. With the macro off: `rsp_err`=0.
- Reset mid-flight: assert `rst_n`=0 with 2 operations in flight and 1 buffered. Required: all outputs 0 immediately, no later `rsp_valid`, and requester 0 granted first after release.
- Valid withdrawal: requester 2 raises valid while requester 1 is granted, then drops valid before being granted. Required: no issue for requester 2 and `last` unchanged by it.

Source files
------------

// File: rtl/fpu_sched_pkg.sv
// Shared types and constants for the fpu_sched block.
// Optional feature macro used by the top: FPU_SCHED_DIV_TRAP_EN.
package fpu_sched_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // Wide enough for the largest supported requester count (8).
  localparam int unsigned ID_W = 3;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            err;
  } tag_t;

  typedef struct packed {
    tag_t        tag;
    logic [31:0] data;
  } rsp_entry_t;

endpackage

// File: rtl/fpu_sched_fifo.sv
// Synchronous FIFO with occupancy count and asynchronous active-low reset.
module fpu_sched_fifo #(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_full    = (r_count == (AW+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_do_push = push & ~w_full;
  assign w_do_pop  = pop & ~empty;
  assign rdata     = r_mem[r_rd_ptr];
  assign count     = r_count;

  // Storage array; contents are only observed through a valid head.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping; power-of-two depth lets pointers wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Upstream credit accounting must never let a push reach a full buffer.
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && w_full));

endmodule

// File: rtl/fpu_sched.sv
// Round-robin scheduler sharing one registered FPU among NREQ requesters.
// Responses return in issue order through a credit-protected buffer.
// Optional macro FPU_SCHED_DIV_TRAP_EN: divides bypass the FPU and return a flagged qNaN.
module fpu_sched
  import fpu_sched_pkg::*;
#(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*32-1:0]       req_a,
  input  logic [NREQ*32-1:0]       req_b,
  input  logic [NREQ*2-1:0]        req_op,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [31:0]              rsp_data,
  output logic                     rsp_err,
  output logic [31:0]              fpu_a,
  output logic [31:0]              fpu_b,
  output logic [1:0]               fpu_op,
  input  logic [31:0]              fpu_outp,
  output logic                     busy
);

  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;

  logic [IDW-1:0] r_last;
  logic           r_s1;
  logic           r_s2;
  tag_t           r_tag1;
  tag_t           r_tag2;
  logic [31:0]    r_fpu_a;
  logic [31:0]    r_fpu_b;
  logic [1:0]     r_fpu_op;

  logic [IDW-1:0] w_cand;
  logic [IDW-1:0] w_grant_idx;
  logic           w_grant_any;
  logic [CW-1:0]  w_occ;
  logic           w_credit_ok;
  logic           w_accept;
  logic [31:0]    w_sel_a;
  logic [31:0]    w_sel_b;
  logic [1:0]     w_sel_op;
  logic           w_is_trap;
  rsp_entry_t     w_push_entry;
  rsp_entry_t     w_head;
  logic [CW-1:0]  w_fifo_count;
  logic           w_fifo_empty;
  logic           w_pop;
  logic           w_unused_tag;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    w_cand      = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      w_cand = IDW'((32'(r_last) + k) % NREQ);
      if (!w_grant_any && req_valid[w_cand]) begin
        w_grant_any = 1'b1;
        w_grant_idx = w_cand;
      end
    end
  end

  // Same-cycle pops are deliberately not credited.
  assign w_occ       = CW'(r_s1) + CW'(r_s2) + w_fifo_count;
  assign w_credit_ok = (w_occ < CW'(FIFO_DEPTH));
  assign w_accept    = w_grant_any & w_credit_ok;

  // One-hot ready for the winner only when a buffer slot is guaranteed.
  always_comb begin
    req_ready = '0;
    if (w_accept) req_ready[w_grant_idx] = 1'b1;
  end

  assign w_sel_a  = req_a[32*w_grant_idx +: 32];
  assign w_sel_b  = req_b[32*w_grant_idx +: 32];
  assign w_sel_op = req_op[2*w_grant_idx +: 2];

`ifdef FPU_SCHED_DIV_TRAP_EN
  assign w_is_trap = (w_sel_op == OP_DIV);
`else
  assign w_is_trap = 1'b0;
`endif

  // Issue registers, tag pipeline aligned with the FPU's sampling edge, and arbiter pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last   <= IDW'(NREQ - 1);
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_tag1   <= '0;
      r_tag2   <= '0;
      r_fpu_a  <= '0;
      r_fpu_b  <= '0;
      r_fpu_op <= '0;
    end else begin
      r_s1   <= w_accept;
      r_s2   <= r_s1;
      r_tag2 <= r_tag1;
      if (w_accept) begin
        r_last     <= w_grant_idx;
        r_tag1.id  <= ID_W'(w_grant_idx);
        r_tag1.err <= w_is_trap;
        // Trapped ops leave the FPU inputs untouched.
        if (!w_is_trap) begin
          r_fpu_a  <= w_sel_a;
          r_fpu_b  <= w_sel_b;
          r_fpu_op <= w_sel_op;
        end
      end
    end
  end

  assign fpu_a  = r_fpu_a;
  assign fpu_b  = r_fpu_b;
  assign fpu_op = r_fpu_op;

  // Trapped results are substituted here so ordering is kept by the buffer.
  assign w_push_entry.tag  = r_tag2;
  assign w_push_entry.data = r_tag2.err ? QNAN : fpu_outp;

  assign w_pop = rsp_valid & rsp_ready;

  fpu_sched_fifo #(
    .WIDTH ($bits(rsp_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (r_s2),
    .wdata (w_push_entry),
    .pop   (w_pop),
    .rdata (w_head),
    .count (w_fifo_count),
    .empty (w_fifo_empty)
  );

  assign rsp_valid = ~w_fifo_empty;
  assign rsp_id    = rsp_valid ? w_head.tag.id[IDW-1:0] : '0;
  assign rsp_data  = rsp_valid ? w_head.data : '0;
`ifdef FPU_SCHED_DIV_TRAP_EN
  assign rsp_err   = rsp_valid & w_head.tag.err;
`else
  assign rsp_err   = 1'b0;
`endif
  assign w_unused_tag = ^{w_head.tag.id, w_head.tag.err};

  assign busy = r_s1 | r_s2 | (w_fifo_count != '0);

endmodule

// File: tb/tb_fpu_sched.sv
// Self-checking bench for fpu_sched with a behavioural FPU stub and a
// transaction-level reference model (outstanding queue + round-robin pointer).
module tb_fpu_sched;

  localparam int NREQ  = 4;
  localparam int DEPTH = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*32-1:0]  req_a = '0;
  logic [NREQ*32-1:0]  req_b = '0;
  logic [NREQ*2-1:0]   req_op = '0;
  logic                rsp_valid;
  logic                rsp_ready = 1'b0;
  logic [1:0]          rsp_id;
  logic [31:0]         rsp_data;
  logic                rsp_err;
  logic [31:0]         fpu_a;
  logic [31:0]         fpu_b;
  logic [1:0]          fpu_op;
  logic [31:0]         fpu_outp = '0;
  logic                busy;

  always #5 clk = ~clk;

  fpu_sched #(.NREQ(NREQ), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op), .fpu_outp(fpu_outp), .busy(busy)
  );

  // Single-precision <-> real conversion for normal numbers (truncating).
  function automatic real sp2r(logic [31:0] x);
    logic [10:0] e;
    if (x[30:0] == 31'd0) return 0.0;
    e = {3'b000, x[30:23]} + 11'd896;
    return $bitstoreal({x[31], e, x[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2sp(real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fpu_fn(logic [31:0] a, logic [31:0] b, logic [1:0] op);
    case (op)
      2'b00:   return r2sp(sp2r(a) + sp2r(b));
      2'b01:   return r2sp(sp2r(a) - sp2r(b));
      2'b10:   return r2sp(sp2r(a) / sp2r(b));
      default: return r2sp(sp2r(a) * sp2r(b));
    endcase
  endfunction

  function automatic bit is_trap(logic [1:0] op);
`ifdef FPU_SCHED_DIV_TRAP_EN
    return op == 2'b10;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] rnd_fp();
    return {1'($urandom_range(1, 0)), 8'($urandom_range(140, 110)), 23'($urandom)};
  endfunction

  // FPU stub: one-cycle registered datapath.
  always @(posedge clk) fpu_outp <= fpu_fn(fpu_a, fpu_b, fpu_op);

  typedef struct {
    int          id;
    logic [31:0] data;
    logic        err;
    int          avail;
  } exp_t;

  exp_t        m_q[$];
  int          m_last = NREQ - 1;
  int          m_cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] e_fa = '0;
  logic [31:0] e_fb = '0;
  logic [1:0]  e_fop = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_op[2*i +: 2]  = op;
  endtask

  // Check one cycle against the model, advance the model, then step one clock.
  task automatic cycle(input string tag, output int g);
    bit          rv;
    int          idx;
    logic [31:0] a, b;
    logic [1:0]  op;
    exp_t        e;
    g = -1;
    #1;
    if (m_q.size() < DEPTH)
      for (int k = 1; k <= NREQ; k++) begin
        idx = (m_last + k) % NREQ;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    chk({tag, ":req_ready"}, 32'(req_ready), (g >= 0) ? 32'(1 << g) : 32'd0);
    rv = (m_q.size() > 0) && (m_q[0].avail <= m_cyc);
    chk({tag, ":rsp_valid"}, 32'(rsp_valid), 32'(rv));
    if (rv) begin
      chk({tag, ":rsp_id"}, 32'(rsp_id), 32'(m_q[0].id));
      chk({tag, ":rsp_data"}, rsp_data, m_q[0].data);
      chk({tag, ":rsp_err"}, 32'(rsp_err), 32'(m_q[0].err));
    end
    chk({tag, ":busy"}, 32'(busy), 32'(m_q.size() != 0));
    chk({tag, ":fpu_a"}, fpu_a, e_fa);
    chk({tag, ":fpu_b"}, fpu_b, e_fb);
    chk({tag, ":fpu_op"}, 32'(fpu_op), 32'(e_fop));
    if (rv && rsp_ready) void'(m_q.pop_front());
    if (g >= 0) begin
      a  = req_a[32*g +: 32];
      b  = req_b[32*g +: 32];
      op = req_op[2*g +: 2];
      e.id = g;
      e.avail = m_cyc + 3;
      if (is_trap(op)) begin
        e.data = 32'h7FC0_0000;
        e.err  = 1'b1;
      end else begin
        e.data = fpu_fn(a, b, op);
        e.err  = 1'b0;
        e_fa = a;
        e_fb = b;
        e_fop = op;
      end
      m_q.push_back(e);
      m_last = g;
    end
    @(posedge clk);
    m_cyc++;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    req_valid = '0;
    rsp_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst:req_ready", 32'(req_ready), 32'd0);
    chk("rst:rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst:rsp_id", 32'(rsp_id), 32'd0);
    chk("rst:rsp_data", rsp_data, 32'd0);
    chk("rst:rsp_err", 32'(rsp_err), 32'd0);
    chk("rst:fpu_a", fpu_a, 32'd0);
    chk("rst:fpu_b", fpu_b, 32'd0);
    chk("rst:fpu_op", 32'(fpu_op), 32'd0);
    chk("rst:busy", 32'(busy), 32'd0);
    m_q.delete();
    m_last = NREQ - 1;
    e_fa = '0;
    e_fb = '0;
    e_fop = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input string tag);
    int g;
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 40 && m_q.size() != 0; i++) cycle(tag, g);
    chk({tag, ":drain_left"}, 32'(m_q.size()), 32'd0);
  endtask

  initial begin
    int             g;
    bit [NREQ-1:0]  hold;
    hold = '0;

    apply_reset();

    // Single add from requester 0.
    rsp_ready = 1'b1;
    set_req(0, 32'h3F80_0000, 32'h3F80_0000, 2'b00);
    req_valid = 4'b0001;
    cycle("add", g);
    req_valid = '0;
    cycle("add", g);
    cycle("add", g);
    chk("add:rsp_valid_e2", 32'(rsp_valid), 32'd1);
    chk("add:rsp_data_e2", rsp_data, 32'h4000_0000);
    cycle("add", g);
    chk("add:busy_after_pop", 32'(busy), 32'd0);

    // Round robin from a fresh reset: grants 0,1,2,3,0,...
    apply_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) set_req(i, rnd_fp(), rnd_fp(), 2'(i));
    set_req(3, 32'h4000_0000, 32'h4000_0000, 2'b11);
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rr:grant", 32'(req_ready), 32'(1 << (k % 4)));
      cycle("rr", g);
    end
    drain("rr");

    // Backpressure: exactly DEPTH accepted, then resume on release.
    rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, rnd_fp(), rnd_fp(), 2'b11);
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) cycle("bp", g);
    #1;
    chk("bp:blocked", 32'(req_ready), 32'd0);
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) cycle("bp_rel", g);
    drain("bp");

    // Divide: known add first so the FPU opcode register holds 00.
    set_req(0, 32'h3F80_0000, 32'h3F80_0000, 2'b00);
    set_req(1, 32'h4040_0000, 32'h3F80_0000, 2'b10);
    req_valid = 4'b0001;
    cycle("div_pre", g);
    drain("div_pre");
    req_valid = 4'b0010;
    cycle("div", g);
    req_valid = '0;
    cycle("div", g);
    cycle("div", g);
`ifdef FPU_SCHED_DIV_TRAP_EN
    chk("div:rsp_data", rsp_data, 32'h7FC0_0000);
    chk("div:rsp_err", 32'(rsp_err), 32'd1);
    chk("div:fpu_op", 32'(fpu_op), 32'd0);
`else
    chk("div:rsp_data", rsp_data, 32'h4040_0000);
    chk("div:rsp_err", 32'(rsp_err), 32'd0);
    chk("div:fpu_op", 32'(fpu_op), 32'd2);
`endif
    drain("div");

    // Reset with two in flight and one buffered.
    rsp_ready = 1'b0;
    set_req(2, rnd_fp(), rnd_fp(), 2'b00);
    req_valid = 4'b0100;
    for (int k = 0; k < 3; k++) cycle("rmid", g);
    req_valid = '0;
    #1;
    chk("rmid:pre_rsp_valid", 32'(rsp_valid), 32'd1);
    apply_reset();
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) cycle("rmid_idle", g);
    req_valid = 4'b1111;
    #1;
    chk("rmid:first_grant", 32'(req_ready), 32'd1);
    cycle("rmid", g);
    drain("rmid");

    // Withdrawal: requester 2 drops valid before being granted.
    req_valid = 4'b0110;
    cycle("wd", g);
    req_valid = 4'b0000;
    cycle("wd", g);
    drain("wd");
    req_valid = 4'b1111;
    #1;
    chk("wd:next_grant", 32'(req_ready), 32'b0100);
    cycle("wd", g);
    drain("wd2");

    // Randomized traffic with hold-until-ready discipline.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!hold[i]) begin
          req_valid[i] = ($urandom_range(2, 0) != 0);
          set_req(i, rnd_fp(), rnd_fp(), 2'($urandom_range(3, 0)));
        end
      rsp_ready = ($urandom_range(3, 0) != 0);
      cycle("rand", g);
      for (int i = 0; i < NREQ; i++) hold[i] = req_valid[i] && (i != g);
    end
    drain("rand");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
